// File: rtl/jtframe_tilemap_romarb.sv
// Shares one ROM read port among N layer fetchers, one-entry data latch each.
// Define JTFRAME_ROMARB_TIMEOUT_EN to release the port after 255 cycles w/o ack.
module jtframe_tilemap_romarb #(
  parameter int N  = 2,
  parameter int AW = 20,
  parameter int DW = 32,
  parameter int RR = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_cs,
  input  logic [N*AW-1:0] req_addr,
  output logic [N*DW-1:0] req_data,
  output logic [N-1:0]    req_ok,
  output logic            rom_cs,
  output logic [AW-1:0]   rom_addr,
  input  logic [DW-1:0]   rom_data,
  input  logic            rom_ok,
  output logic            busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SKIP = 2'd1,
    WAIT = 2'd2
  } st_t;

  st_t st, st_nx;

  logic [IW-1:0] ptr, gnt, pick, ix;
  logic [N-1:0]  valid, hit, pend;
  logic [AW-1:0] last_addr [N];
  logic [DW-1:0] data [N];
  logic          any_pend, accept, tmo;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      hit[i]  = valid[i] && (req_addr[i*AW +: AW] == last_addr[i]);
      pend[i] = req_cs[i] && !hit[i];
    end
    any_pend = |pend;
  end

  // scan from the highest distance down so the nearest pending index wins
  always_comb begin
    pick = '0;
    ix   = '0;
    if (RR != 0) begin
      for (int k = N; k >= 1; k--) begin
        ix = IW'((int'(ptr) + k) % N);
        if (pend[ix]) pick = ix;
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        if (pend[k]) pick = IW'(k);
      end
    end
  end

  assign accept = (st == WAIT) && rom_ok;

`ifdef JTFRAME_ROMARB_TIMEOUT_EN
  logic [7:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (st == IDLE)  cnt <= '0;
    else                  cnt <= cnt + 8'd1;
  end

  // the increment that would land on 255 releases the port instead
  assign tmo = (st == WAIT) && !rom_ok && (cnt == 8'd254);
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE:    if (any_pend) st_nx = SKIP;
      SKIP:    st_nx = WAIT;
      WAIT:    if (accept || tmo) st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ok   = req_cs & hit;
    busy     = (st != IDLE);
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      req_data[i*DW +: DW] = data[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_cs   <= 1'b0;
      rom_addr <= '0;
      gnt      <= '0;
      ptr      <= IW'(N - 1);
      valid    <= '0;
      for (int i = 0; i < N; i++) begin
        last_addr[i] <= '0;
        data[i]      <= '0;
      end
    end else begin
      unique case (st)
        IDLE: begin
          if (any_pend) begin
            gnt      <= pick;
            rom_cs   <= 1'b1;
            rom_addr <= req_addr[int'(pick)*AW +: AW];
          end
        end
        WAIT: begin
          if (accept || tmo) begin
            rom_cs         <= 1'b0;
            ptr            <= gnt;
            valid[gnt]     <= 1'b1;
            last_addr[gnt] <= rom_addr;
            data[gnt]      <= accept ? rom_data : '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_tilemap_romarb.sv
// Bench for jtframe_tilemap_romarb: RR=1 and RR=0 copies driven in parallel,
// each scored against its own cache/arbitration reference model.
module tb_jtframe_tilemap_romarb;

  localparam int N  = 2;
  localparam int AW = 20;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req_cs;
  logic [N*AW-1:0] req_addr;

  logic [N*DW-1:0] req_data_v [2];
  logic [N-1:0]    req_ok_v   [2];
  logic            rom_cs_v   [2];
  logic [AW-1:0]   rom_addr_v [2];
  logic [DW-1:0]   rom_data_v [2];
  logic            rom_ok_v   [2];
  logic            busy_v     [2];

  jtframe_tilemap_romarb #(.N(N), .AW(AW), .DW(DW), .RR(1)) u_rr (
    .clk      (clk),
    .rst      (rst),
    .req_cs   (req_cs),
    .req_addr (req_addr),
    .req_data (req_data_v[0]),
    .req_ok   (req_ok_v[0]),
    .rom_cs   (rom_cs_v[0]),
    .rom_addr (rom_addr_v[0]),
    .rom_data (rom_data_v[0]),
    .rom_ok   (rom_ok_v[0]),
    .busy     (busy_v[0])
  );

  jtframe_tilemap_romarb #(.N(N), .AW(AW), .DW(DW), .RR(0)) u_fp (
    .clk      (clk),
    .rst      (rst),
    .req_cs   (req_cs),
    .req_addr (req_addr),
    .req_data (req_data_v[1]),
    .req_ok   (req_ok_v[1]),
    .rom_cs   (rom_cs_v[1]),
    .rom_addr (rom_addr_v[1]),
    .rom_data (rom_data_v[1]),
    .rom_ok   (rom_ok_v[1]),
    .busy     (busy_v[1])
  );

  bit            mval  [2][N];
  logic [AW-1:0] maddr [2][N];
  logic [DW-1:0] mdat  [2][N];
  int            mptr[2], mg[2], ndone[2], ngr[2];
  int            lastid[2], hilen[2], lastlen[2], wcnt[2];
  bit            infl[2], prev_cs[2];
  logic [AW-1:0] mta[2];
  logic [N-1:0]  spend[2];
  logic [N*AW-1:0] saddr;
  int            lat;
  bit            stale, noresp, alt_mode;
  int            n_chk, n_pass;

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    if (a == 20'h00123) return 32'hDEADBEEF;
    return {a[11:0], a} ^ 32'h5A5A_0F0F;
  endfunction

  // d=0: round robin after the last served index; d=1: lowest index
  function automatic int pick(input int d, input logic [N-1:0] p);
    if (d == 0) begin
      for (int k = 1; k <= N; k++)
        if (p[(mptr[d] + k) % N]) return (mptr[d] + k) % N;
    end else begin
      for (int i = 0; i < N; i++)
        if (p[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mptr[d] = N - 1;
      infl[d] = 0;
      prev_cs[d] = 0;
      wcnt[d] = 0;
      hilen[d] = 0;
      rom_ok_v[d] = 1'b0;
      rom_data_v[d] = '0;
      for (int i = 0; i < N; i++) begin
        mval[d][i] = 0;
        maddr[d][i] = '0;
        mdat[d][i] = '0;
      end
    end
  endtask

  task automatic step();
    int g, id;
    bit eo;
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) begin
        eo = req_cs[i] && mval[d][i] &&
             (maddr[d][i] == req_addr[i*AW +: AW]);
        spend[d][i] = req_cs[i] && !eo;
        n_chk++;
        if (req_ok_v[d][i] !== eo)
          $display("FAIL req_ok dut%0d[%0d]: got %b required %b",
                   d, i, req_ok_v[d][i], eo);
        else n_pass++;
        n_chk++;
        if (req_data_v[d][i*DW +: DW] !== mdat[d][i])
          $display("FAIL req_data dut%0d[%0d]: got %h required %h",
                   d, i, req_data_v[d][i*DW +: DW], mdat[d][i]);
        else n_pass++;
      end
      n_chk++;
      if (busy_v[d] !== infl[d])
        $display("FAIL busy dut%0d: got %b required %b", d, busy_v[d], infl[d]);
      else n_pass++;
    end
    saddr = req_addr;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (rom_cs_v[d] && !prev_cs[d]) begin
        g = pick(d, spend[d]);
        n_chk++;
        if (g < 0)
          $display("FAIL grant dut%0d: rom_cs rose, required no request", d);
        else if (rom_addr_v[d] !== saddr[g*AW +: AW])
          $display("FAIL grant_addr dut%0d: rom_addr %h required %h",
                   d, rom_addr_v[d], saddr[g*AW +: AW]);
        else n_pass++;
        mg[d] = (g < 0) ? 0 : g;
        mta[d] = (g < 0) ? rom_addr_v[d] : saddr[mg[d]*AW +: AW];
        infl[d] = 1;
        hilen[d] = 1;
        ngr[d]++;
        if (alt_mode) begin
          id = -1;
          for (int i = 0; i < N; i++)
            if (id < 0 && saddr[i*AW +: AW] == rom_addr_v[d]) id = i;
          n_chk++;
          if (d == 0 && (id < 0 || id == lastid[0]))
            $display("FAIL rr_alternate: granted %0d after %0d", id, lastid[0]);
          else if (d == 1 && id != 0)
            $display("FAIL fixed_prio: granted %0d required 0", id);
          else n_pass++;
          lastid[d] = id;
        end
      end else if (rom_cs_v[d]) begin
        hilen[d]++;
      end else if (prev_cs[d]) begin
        mval[d][mg[d]] = 1;
        maddr[d][mg[d]] = mta[d];
        mdat[d][mg[d]] = noresp ? '0 : rom_f(mta[d]);
        mptr[d] = mg[d];
        infl[d] = 0;
        ndone[d]++;
        lastlen[d] = hilen[d];
      end else begin
        n_chk++;
        if (spend[d] != '0)
          $display("FAIL missed_grant dut%0d: rom_cs 0 required 1 (pend %b)",
                   d, spend[d]);
        else n_pass++;
      end
      prev_cs[d] = rom_cs_v[d];
      if (noresp) begin
        rom_ok_v[d] = 1'b0;
      end else if (stale) begin
        rom_ok_v[d] = 1'b1;
        rom_data_v[d] = rom_f(rom_addr_v[d]);
      end else if (rom_cs_v[d]) begin
        if (!rom_ok_v[d]) begin
          wcnt[d]++;
          if (wcnt[d] > lat) begin
            rom_ok_v[d] = 1'b1;
            rom_data_v[d] = rom_f(rom_addr_v[d]);
          end
        end
      end else begin
        rom_ok_v[d] = 1'b0;
        wcnt[d] = 0;
      end
    end
  endtask

  task automatic wait_txn(input int bound);
    int b0, b1, k;
    b0 = ndone[0];
    b1 = ndone[1];
    k = 0;
    while (k < bound && (ndone[0] == b0 || ndone[1] == b1)) begin
      step();
      k++;
    end
    n_chk++;
    if (ndone[0] == b0 || ndone[1] == b1)
      $display("FAIL txn_timeout: done %0d/%0d required one more", ndone[0], ndone[1]);
    else n_pass++;
  endtask

  task automatic wait_rise(input int bound);
    int b0, b1, k;
    b0 = ngr[0];
    b1 = ngr[1];
    k = 0;
    while (k < bound && (ngr[0] == b0 || ngr[1] == b1)) begin
      step();
      k++;
    end
    n_chk++;
    if (ngr[0] == b0 || ngr[1] == b1)
      $display("FAIL rise_timeout: grants %0d/%0d required one more", ngr[0], ngr[1]);
    else n_pass++;
  endtask

  task automatic drain();
    int k;
    req_cs = '0;
    stale = 0;
    repeat (2) step();
    k = 0;
    while (k < 400 && (rom_cs_v[0] || rom_cs_v[1])) begin
      step();
      k++;
    end
    n_chk++;
    if (rom_cs_v[0] || rom_cs_v[1])
      $display("FAIL drain: rom_cs %b%b required 00", rom_cs_v[0], rom_cs_v[1]);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_cs = '0;
    req_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (rom_cs_v[d] !== 1'b0) $display("FAIL rst_rom_cs dut%0d: got %b required 0", d, rom_cs_v[d]);
      else n_pass++;
      n_chk++;
      if (rom_addr_v[d] !== '0) $display("FAIL rst_rom_addr dut%0d: got %h required 0", d, rom_addr_v[d]);
      else n_pass++;
      n_chk++;
      if (busy_v[d] !== 1'b0) $display("FAIL rst_busy dut%0d: got %b required 0", d, busy_v[d]);
      else n_pass++;
      n_chk++;
      if (req_data_v[d] !== '0) $display("FAIL rst_data dut%0d: got %h required 0", d, req_data_v[d]);
      else n_pass++;
    end
    rst = 1'b0;
  endtask

  task automatic test_single_miss();
    lat = 2;
    req_cs = 2'b01;
    req_addr[0 +: AW] = 20'h00123;
    wait_txn(20);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (req_ok_v[d][0] !== 1'b1 || req_data_v[d][DW-1:0] !== 32'hDEADBEEF)
        $display("FAIL miss_fill dut%0d: ok %b data %h required 1 deadbeef",
                 d, req_ok_v[d][0], req_data_v[d][DW-1:0]);
      else n_pass++;
      n_chk++;
      if (busy_v[d] !== 1'b0) $display("FAIL miss_busy dut%0d: got %b required 0", d, busy_v[d]);
      else n_pass++;
    end
  endtask

  task automatic test_hit();
    int g0, g1;
    g0 = ngr[0];
    g1 = ngr[1];
    repeat (4) step();
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (req_ok_v[d][0] !== 1'b1) $display("FAIL hit_ok dut%0d: got %b required 1", d, req_ok_v[d][0]);
      else n_pass++;
    end
    n_chk++;
    if (ngr[0] != g0 || ngr[1] != g1)
      $display("FAIL hit_no_rom: grants %0d/%0d required %0d/%0d", ngr[0], ngr[1], g0, g1);
    else n_pass++;
  endtask

  task automatic test_alternate();
    int g0, g1;
    g0 = ngr[0];
    g1 = ngr[1];
    lat = 0;
    alt_mode = 1;
    lastid[0] = -1;
    lastid[1] = -1;
    for (int c = 0; c < 48; c++) begin
      req_cs = 2'b11;
      req_addr[0 +: AW] = AW'(32'h40000 + c);
      req_addr[AW +: AW] = AW'(32'h80000 + c);
      step();
    end
    alt_mode = 0;
    n_chk++;
    if (ngr[0] - g0 < 6 || ngr[1] - g1 < 6)
      $display("FAIL alt_count: grants %0d/%0d required >=6", ngr[0] - g0, ngr[1] - g1);
    else n_pass++;
    drain();
  endtask

  task automatic test_stale();
    stale = 1;
    req_cs = 2'b01;
    req_addr[0 +: AW] = 20'h00777;
    wait_txn(20);
    req_addr[0 +: AW] = 20'h00778;
    wait_txn(20);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (lastlen[d] != 2) $display("FAIL stale_skip dut%0d: cs high %0d cycles required 2", d, lastlen[d]);
      else n_pass++;
      n_chk++;
      if (req_data_v[d][DW-1:0] !== rom_f(20'h00778))
        $display("FAIL stale_data dut%0d: got %h required %h", d, req_data_v[d][DW-1:0], rom_f(20'h00778));
      else n_pass++;
    end
    drain();
  endtask

  task automatic test_addr_change();
    lat = 4;
    req_cs = 2'b10;
    req_addr[AW +: AW] = 20'h00010;
    wait_rise(10);
    step();
    req_addr[AW +: AW] = 20'h00020;
    wait_txn(20);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (req_ok_v[d][1] !== 1'b0) $display("FAIL chg_ok dut%0d: got %b required 0", d, req_ok_v[d][1]);
      else n_pass++;
    end
    wait_rise(10);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (rom_addr_v[d] !== 20'h00020) $display("FAIL chg_addr dut%0d: got %h required 00020", d, rom_addr_v[d]);
      else n_pass++;
    end
    wait_txn(20);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (req_ok_v[d][1] !== 1'b1) $display("FAIL chg_ok2 dut%0d: got %b required 1", d, req_ok_v[d][1]);
      else n_pass++;
    end
    drain();
  endtask

  task automatic test_reset_mid();
    lat = 1;
    req_cs = 2'b01;
    req_addr[0 +: AW] = 20'h00555;
    wait_txn(20);
    lat = 10;
    req_addr[0 +: AW] = 20'h00556;
    wait_rise(10);
    step();
    step();
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (rom_cs_v[d] !== 1'b0 || busy_v[d] !== 1'b0 || req_ok_v[d] !== '0)
        $display("FAIL mid_rst dut%0d: cs %b busy %b ok %b required 0 0 00",
                 d, rom_cs_v[d], busy_v[d], req_ok_v[d]);
      else n_pass++;
    end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    req_addr[0 +: AW] = 20'h00555;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (req_ok_v[d][0] !== 1'b0) $display("FAIL post_rst_miss dut%0d: got %b required 0", d, req_ok_v[d][0]);
      else n_pass++;
    end
    lat = 1;
    wait_txn(20);
    drain();
  endtask

`ifdef JTFRAME_ROMARB_TIMEOUT_EN
  task automatic test_timeout();
    noresp = 1;
    req_cs = 2'b01;
    req_addr[0 +: AW] = 20'h00999;
    wait_txn(300);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (lastlen[d] != 255) $display("FAIL tmo_len dut%0d: cs high %0d cycles required 255", d, lastlen[d]);
      else n_pass++;
      n_chk++;
      if (req_ok_v[d][0] !== 1'b1 || req_data_v[d][DW-1:0] !== '0)
        $display("FAIL tmo_fill dut%0d: ok %b data %h required 1 0",
                 d, req_ok_v[d][0], req_data_v[d][DW-1:0]);
      else n_pass++;
    end
    noresp = 0;
    drain();
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      req_cs = N'($urandom);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 2) == 0)
          req_addr[i*AW +: AW] = AW'($urandom_range(0, 5));
      lat = $urandom_range(0, 3);
      step();
    end
    drain();
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    lat = 1;
    stale = 0;
    noresp = 0;
    alt_mode = 0;
    for (int d = 0; d < 2; d++) begin
      ndone[d] = 0;
      ngr[d] = 0;
      lastlen[d] = 0;
      mg[d] = 0;
      mta[d] = '0;
    end
    test_reset();
    test_single_miss();
    test_hit();
    test_alternate();
    test_stale();
    test_addr_change();
    test_reset_mid();
`ifdef JTFRAME_ROMARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
